// File: rtl/coin_acceptor.sv
// Coin-switch front end: synchronises and debounces three raw coin levels and emits one
// single-cycle pulse per accepted coin, or coin_reject for a multi-coin press.
`timescale 1ns/1ps

module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic nickle_raw,
    input  logic dime_raw,
    input  logic quarter_raw,
    output logic nickle,
    output logic dime,
    output logic quarter,
    output logic coin_reject,
    output logic busy
);

    typedef enum logic [1:0] {StIdle, StQual, StEmit, StRel} state_e;

    state_e           state_q, state_d;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             count_done;
    logic [2:0]       sv;

    assign sv         = sync2_q;
    assign count_inc  = count_q + CNT_W'(1);
    // The sample being taken now is the DEBOUNCE_CYCLES-th identical one.
    assign count_done = (count_inc == CNT_W'(DEBOUNCE_CYCLES));

    always_comb begin
        sync1_d = {quarter_raw, dime_raw, nickle_raw};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            code_q  <= '0;
            count_q <= '0;
            state_q <= StIdle;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            code_q  <= code_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (sv != 3'b000) begin
                    code_d  = sv;
                    count_d = CNT_W'(1);
                    state_d = StQual;
                end
            end
            StQual: begin
                if (sv == 3'b000) begin
                    state_d = StIdle;
                end else if (sv == code_q) begin
                    count_d = count_inc;
                    if (count_done) begin
                        state_d = StEmit;
                    end
                end else begin
                    // Bounce or a second coin joining: requalify the new pattern from scratch.
                    code_d  = sv;
                    count_d = CNT_W'(1);
                end
            end
            StEmit: begin
                count_d = '0;
                state_d = StRel;
            end
            StRel: begin
                if (sv == 3'b000) begin
                    count_d = count_inc;
                    if (count_done) begin
                        state_d = StIdle;
                    end
                end else begin
                    count_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        nickle      = 1'b0;
        dime        = 1'b0;
        quarter     = 1'b0;
        coin_reject = 1'b0;
        busy        = (state_q != StIdle);
        if (state_q == StEmit) begin
            case (code_q)
                3'b001:  nickle      = 1'b1;
                3'b010:  dime        = 1'b1;
                3'b100:  quarter     = 1'b1;
                3'b000:  ;
                default: coin_reject = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4 and a 100 ns clock.
// Inputs change 1 ns after a rising edge; "edge e" is the e-th edge after the change.
`timescale 1ns/1ps

module tb_coin_acceptor;

    logic clk;
    logic reset;
    logic nickle_raw, dime_raw, quarter_raw;
    logic nickle, dime, quarter, coin_reject, busy;

    int checks;
    int errors;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nickle_raw (nickle_raw),
        .dime_raw   (dime_raw),
        .quarter_raw(quarter_raw),
        .nickle     (nickle),
        .dime       (dime),
        .quarter    (quarter),
        .coin_reject(coin_reject),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Vector layout: {nickle, dime, quarter, coin_reject, busy}
    task automatic test_reset();
        logic [4:0] obs;
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            nickle_raw  = e[0];
            dime_raw    = e[1];
            quarter_raw = ~e[0];
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold e=%0d got %b want 00000", e, obs);
            end
        end
        nickle_raw  = 1'b0;
        dime_raw    = 1'b0;
        quarter_raw = 1'b0;
        step();
        reset = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset_release e=%0d got %b want 00000", e, obs);
            end
        end
    endtask

    task automatic test_nickle();
        logic [4:0] obs, exp;
        for (int e = 0; e <= 20; e++) begin
            nickle_raw = (e < 12);
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            exp = {(e == 5), 1'b0, 1'b0, 1'b0, (e >= 2 && e <= 16)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL nickle e=%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_short_press();
        logic [4:0] obs, exp;
        for (int e = 0; e <= 9; e++) begin
            dime_raw = (e < 2);
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            exp = {4'b0000, (e == 2 || e == 3)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL short_press e=%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_multi_coin();
        logic [4:0] obs, exp;
        for (int e = 0; e <= 17; e++) begin
            dime_raw    = (e < 10);
            quarter_raw = (e < 10);
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            exp = {3'b000, (e == 5), (e >= 2 && e <= 14)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL multi_coin e=%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0]  obs, exp;
        logic [12:0] pat;
        pat = 13'b11111111_01101;  // LSB first: 1,0,1,1,0 then eight 1s
        for (int e = 0; e <= 19; e++) begin
            quarter_raw = (e < 13) ? pat[e] : 1'b0;
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            exp = {2'b00, (e == 10), 1'b0, obs[0]};
            if (e == 19) exp[0] = 1'b0;
            if (e >= 7 && e <= 17) exp[0] = 1'b1;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bounce e=%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs, exp;
        logic [2:0] coins [3];
        int         total;
        coins[0] = 3'b001;
        coins[1] = 3'b010;
        coins[2] = 3'b010;
        total    = 0;
        for (int c = 0; c < 3; c++) begin
            for (int e = 0; e <= 14; e++) begin
                nickle_raw  = (e < 6) && coins[c][0];
                dime_raw    = (e < 6) && coins[c][1];
                quarter_raw = (e < 6) && coins[c][2];
                step();
                if (nickle)  total += 5;
                if (dime)    total += 10;
                if (quarter) total += 25;
                obs = {nickle, dime, quarter, coin_reject, busy};
                exp = {(e == 5) && coins[c][0], (e == 5) && coins[c][1],
                       (e == 5) && coins[c][2], 1'b0, (e >= 2 && e <= 10)};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL back_to_back coin=%0d e=%0d got %b want %b", c, e, obs, exp);
                end
            end
        end
        checks++;
        if (total != 25) begin
            errors++;
            $display("FAIL back_to_back_total got %0d want 25", total);
        end
    endtask

    task automatic test_reset_abort();
        logic [4:0] obs, exp;
        bit         idle_seen;
        for (int e = 0; e <= 5; e++) begin
            nickle_raw = 1'b1;
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            exp = {(e == 5), 3'b000, (e >= 2)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_press e=%0d got %b want %b", e, obs, exp);
            end
        end
        #10;
        reset = 1'b0;
        #1;
        obs = {nickle, dime, quarter, coin_reject, busy};
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL abort_async got %b want 00000", obs);
        end
        step();
        reset = 1'b1;
        // Coin still held: must be qualified again as a fresh press.
        for (int e = 0; e <= 7; e++) begin
            step();
            obs = {nickle, dime, quarter, coin_reject, busy};
            exp = {(e == 5), 3'b000, (e >= 2)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_repress e=%0d got %b want %b", e, obs, exp);
            end
        end
        nickle_raw = 1'b0;
        idle_seen  = 1'b0;
        for (int e = 0; e < 20 && !idle_seen; e++) begin
            step();
            if (!busy) idle_seen = 1'b1;
        end
        checks++;
        if (!idle_seen) begin
            errors++;
            $display("FAIL abort_drain got busy=1 want busy=0 within 20 cycles");
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        nickle_raw  = 1'b0;
        dime_raw    = 1'b0;
        quarter_raw = 1'b0;
        test_reset();
        test_nickle();
        test_short_press();
        test_multi_coin();
        test_bounce();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
